// File: rtl/stream_pkg.sv
// Shared constants and types for the four-source stream multiplexer.
package stream_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int SEL_W         = 2;
  localparam int NUM_SRC       = 4;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin arbiter. The first requester at or after
// ptr, taken in cyclic order, wins.
module rr_arbiter4
  import stream_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  sel_t               ptr,
  output logic               gnt_valid,
  output sel_t               gnt_idx
);

  sel_t idx_s;

  // Scan from the farthest offset back to ptr so that the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx_s     = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx_s     = ptr + sel_t'(k);
      gnt_valid = gnt_valid | req[idx_s];
      gnt_idx   = req[idx_s] ? idx_s : gnt_idx;
    end
  end

endmodule

// File: rtl/mux4_stream.sv
// Four-source valid/ready stream multiplexer with round-robin arbitration and
// a one-entry output register that sustains one word per cycle.
module mux4_stream
  import stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  output logic [NUM_SRC-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output sel_t                     out_sel,
  input  logic                     out_ready
);

  sel_t             ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  sel_t             out_sel_q, out_sel_d;

  logic             load_en_s;
  logic             gnt_valid_s;
  sel_t             gnt_idx_s;
  logic             in_xfer_s;
  logic [WIDTH-1:0] mux_word_s;

  // The register can take a new word when empty or when it is being drained now.
  assign load_en_s = !out_valid_q || out_ready;
  assign in_xfer_s = load_en_s && gnt_valid_s;

  rr_arbiter4 u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Word select for the granted source.
  always_comb begin
    mux_word_s = {WIDTH{1'b0}};
    case (gnt_idx_s)
      2'd0:    mux_word_s = in_data[0*WIDTH +: WIDTH];
      2'd1:    mux_word_s = in_data[1*WIDTH +: WIDTH];
      2'd2:    mux_word_s = in_data[2*WIDTH +: WIDTH];
      2'd3:    mux_word_s = in_data[3*WIDTH +: WIDTH];
      default: mux_word_s = {WIDTH{1'b0}};
    endcase
  end

  // One-hot ready to the granted source only; suppressed while reset is held.
  always_comb begin
    in_ready = 4'b0000;
    if (!reset && in_xfer_s) begin
      in_ready = 4'b0001 << gnt_idx_s;
    end else begin
      in_ready = 4'b0000;
    end
  end

  // Next state: load on an input transfer, otherwise drain or hold.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (in_xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_word_s;
      out_sel_d   = gnt_idx_s;
      ptr_d       = gnt_idx_s + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State register with synchronous reset that discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/mux4_stream.md
MUX4_STREAM -- requirements
Module: mux4_stream

Interface
REQ-001 Parameter WIDTH, default 16, shall set the data word width of every channel.
REQ-002 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  shall be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  4  shall carry one valid bit per source channel; bit i is source i.
REQ-005 in_data  input  4*WIDTH  shall carry the source words; bits [i*WIDTH +: WIDTH] belong to source i.
REQ-006 in_ready  output  4  shall carry one ready bit per source; a transfer on source i occurs when in_valid[i] and in_ready[i] are both high.
REQ-007 out_valid  output  1  shall be high while the output register holds a word.
REQ-008 out_data  output  WIDTH  shall be the registered word.
REQ-009 out_sel  output  2  shall be the registered index (00..11) of the source that supplied out_data.
REQ-010 out_ready  input  1  shall be the sink acceptance; an output transfer occurs when out_valid and out_ready are both high.

Function
REQ-011 The block shall contain a one-entry output register (data, sel, full flag) and a 2-bit round-robin pointer ptr.
REQ-012 load_en shall be high when !out_valid, or when out_valid and out_ready are both high.
REQ-013 The grant shall go to the first requesting source in cyclic order ptr, ptr+1, ptr+2, ptr+3 (mod 4); with no requests there is no grant.
REQ-014 in_ready[i] shall be high only when load_en is high and i is the granted source; at most one in_ready bit shall be high in any cycle.
REQ-015 in_ready shall be computed from in_valid, ptr, out_valid and out_ready, and shall not depend on in_data.
REQ-016 On an input transfer from source g, the output register shall capture in_data[g], set out_sel to g and out_valid to 1 on the next edge (latency 1 cycle).
REQ-017 On an input transfer from source g, ptr shall become g+1 mod 4 (wrap 3 -> 0); otherwise ptr shall hold.
REQ-018 On an output transfer with no simultaneous input transfer, out_valid shall clear.
REQ-019 A simultaneous output and input transfer shall replace the register contents with no bubble, sustaining 1 word per cycle.
REQ-020 While out_valid is high and out_ready is low, out_data, out_sel and out_valid shall hold, and all in_ready bits shall be low.
REQ-021 A source whose in_valid is high and not granted shall not be consumed; it waits at most 3 grants to other sources (starvation-free).
REQ-022 Data order per source shall be preserved; no word shall be duplicated or dropped.

Reset
REQ-023 While reset is high, out_valid shall be 0, out_data 0, out_sel 00, ptr 00, and in_ready 0000.
REQ-024 Reset asserted mid-operation shall discard any held word in the cycle it is sampled, with no output transfer reported.
REQ-025 After reset deasserts, source 0 shall have the highest priority on the first arbitration.

Structure
REQ-026 A shared package stream_pkg shall define WIDTH_DEFAULT = 16, SEL_W = 2 and NUM_SRC = 4.
REQ-027 The round-robin selection shall be a combinational sub-module rr_arbiter4 (inputs req[3:0], ptr[1:0]; outputs gnt_valid, gnt_idx[1:0]).
REQ-028 The datapath selection shall be a 4:1 word mux indexed by gnt_idx.

Verification
REQ-029 After reset, set in_valid=0001, in_data[0]=16'hA5A5, out_ready=1 -> next cycle out_valid=1, out_data=A5A5, out_sel=00; ptr=01.
REQ-030 Hold in_valid=1111 with distinct words and out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle, no bubbles.
REQ-031 With out_valid=1 and out_ready=0 for 5 cycles under in_valid=1111 -> out_data/out_sel stable, in_ready=0000; out_ready=1 -> transfer resumes at ptr.
REQ-032 With ptr=11 and in_valid=1001 -> source 3 is granted first, then source 0 (wrap-around); ptr ends at 01.
REQ-033 Assert reset for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_sel=00, ptr=00; no out transfer observed.
REQ-034 Run a randomized valid/ready scoreboard over 10000 cycles with per-source FIFOs -> zero mismatches, and every waiting source served within 4 grants.
